// File: rtl/aidc_lite_comp_zrle_if.sv
// Line-in / code-stream-out bundle for the ZRLE compressor.
// slave  : seen from the compressor (takes a line, drives the stream)
// master : seen from the producer/consumer side (testbench, wrapper)
interface aidc_lite_comp_zrle_if;
    logic         valid_i;
    logic         ready_o;
    logic [511:0] data_i;
    logic         valid_o;
    logic         sop_o;
    logic         eop_o;
    logic [31:0]  data_o;
    logic         done_o;
    logic         fail_o;
    logic [4:0]   size_o;

    modport slave (
        input  valid_i, data_i,
        output ready_o, valid_o, sop_o, eop_o, data_o, done_o, fail_o, size_o
    );

    modport master (
        output valid_i, data_i,
        input  ready_o, valid_o, sop_o, eop_o, data_o, done_o, fail_o, size_o
    );
endinterface

// File: rtl/aidc_lite_comp_zrle.sv
// Zero-run-length compressor for one 512-bit line (8 words x 4 symbols).
// Emits a 32-bit sop/eop code stream, 2-bit algorithm prefix first, MSB-first.
// Lines whose code exceeds MAX_CODE_BITS are rejected with fail_o.
// Optional macro AIDC_LITE_COMP_ZRLE_STATS_EN adds saturating line/fail counters.
module aidc_lite_comp_zrle #(
    parameter logic [1:0] PREFIX        = 2'b01,
    parameter int         MAX_CODE_BITS = 510
) (
    input  logic                  clk,
    input  logic                  rst,
    aidc_lite_comp_zrle_if.slave  bus
`ifdef AIDC_LITE_COMP_ZRLE_STATS_EN
    ,
    input  logic                  stat_clr_i,
    output logic [31:0]           stat_lines_o,
    output logic [31:0]           stat_fail_o
`endif
);

    localparam logic [9:0] MAX_BITS_C = 10'(MAX_CODE_BITS);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LEN  = 2'd1,
        ST_ENC  = 2'd2
    } state_e;

    // Code of one word, left-justified in 66 bits: tag then nonzero symbols S3..S0.
    function automatic logic [65:0] zrle_code(input logic [63:0] w);
        logic [3:0]  pat;
        logic [65:0] c;
        pat = {|w[63:48], |w[47:32], |w[31:16], |w[15:0]};
        case (pat)
            4'b0000: c = {6'b000000, 60'd0};
            4'b0001: c = {6'b000001, w[15:0], 44'd0};
            4'b0010: c = {5'b00001, w[31:16], 45'd0};
            4'b0100: c = {5'b00010, w[47:32], 45'd0};
            4'b1000: c = {5'b00011, w[63:48], 45'd0};
            4'b0011: c = {4'b0010, w[31:16], w[15:0], 30'd0};
            4'b0101: c = {4'b0011, w[47:32], w[15:0], 30'd0};
            4'b1001: c = {4'b0100, w[63:48], w[15:0], 30'd0};
            4'b0110: c = {4'b0101, w[47:32], w[31:16], 30'd0};
            4'b1010: c = {4'b0110, w[63:48], w[31:16], 30'd0};
            4'b1100: c = {4'b0111, w[63:48], w[47:32], 30'd0};
            4'b0111: c = {4'b1000, w[47:32], w[31:16], w[15:0], 14'd0};
            4'b1011: c = {4'b1001, w[63:48], w[31:16], w[15:0], 14'd0};
            4'b1101: c = {4'b1010, w[63:48], w[47:32], w[15:0], 14'd0};
            4'b1110: c = {4'b1011, w[63:48], w[47:32], w[31:16], 14'd0};
            4'b1111: c = {2'b11, w};
            default: c = 66'd0;
        endcase
        return c;
    endfunction

    // Code length of one word; depends only on how many symbols are nonzero
    // (and, for a single symbol, whether it is S0).
    function automatic logic [6:0] zrle_len(input logic [63:0] w);
        logic [3:0] pat;
        logic [6:0] n;
        pat = {|w[63:48], |w[47:32], |w[31:16], |w[15:0]};
        case (pat)
            4'b0000:                            n = 7'd6;
            4'b0001:                            n = 7'd22;
            4'b0010, 4'b0100, 4'b1000:          n = 7'd21;
            4'b0011, 4'b0101, 4'b1001,
            4'b0110, 4'b1010, 4'b1100:          n = 7'd36;
            4'b0111, 4'b1011, 4'b1101, 4'b1110: n = 7'd52;
            4'b1111:                            n = 7'd66;
            default:                            n = 7'd0;
        endcase
        return n;
    endfunction

    state_e         state_q;
    logic [511:0]   line_q;
    logic [127:0]   acc_q;
    logic [7:0]     bits_q;
    logic [3:0]     k_q;
    logic [4:0]     nwords_q;
    logic [4:0]     wcnt_q;
    logic           ready_q;
    logic           valid_q;
    logic           sop_q;
    logic           eop_q;
    logic [31:0]    data_q;
    logic           done_q;
    logic           fail_q;
    logic [4:0]     size_q;

    logic [9:0]     len_sum_s;
    logic [9:0]     len_pad_s;
    logic [63:0]    cur_word_s;
    logic [65:0]    cur_code_s;
    logic [6:0]     cur_len_s;
    logic           emit_full_s;
    logic           emit_tail_s;
    logic           emit_s;
    logic           append_s;
    logic           last_s;
    logic [127:0]   acc_e_s;
    logic [7:0]     bits_e_s;
    logic [127:0]   acc_d;
    logic [7:0]     bits_d;

    // Total code length of the latched line, used in LEN.
    always_comb begin
        len_sum_s = 10'd0;
        for (int i = 0; i < 8; i++) begin
            len_sum_s = len_sum_s + {3'd0, zrle_len(line_q[i*64 +: 64])};
        end
        len_pad_s = len_sum_s + 10'd33;
    end

    // ENC datapath: emit a full/tail word, then append the next code if room.
    always_comb begin
        cur_word_s  = line_q[{k_q[2:0], 6'd0} +: 64];
        cur_code_s  = zrle_code(cur_word_s);
        cur_len_s   = zrle_len(cur_word_s);
        emit_full_s = (bits_q >= 8'd32);
        emit_tail_s = (bits_q != 8'd0) && (k_q == 4'd8);
        emit_s      = (state_q == ST_ENC) && (emit_full_s || emit_tail_s);
        last_s      = (wcnt_q == (nwords_q - 5'd1));
        if (emit_full_s) begin
            acc_e_s  = acc_q << 32;
            bits_e_s = bits_q - 8'd32;
        end else if (emit_tail_s) begin
            acc_e_s  = 128'd0;
            bits_e_s = 8'd0;
        end else begin
            acc_e_s  = acc_q;
            bits_e_s = bits_q;
        end
        append_s = (state_q == ST_ENC) && (bits_e_s < 8'd32) && (k_q < 4'd8);
        if (append_s) begin
            acc_d  = acc_e_s | ({cur_code_s, 62'd0} >> bits_e_s);
            bits_d = bits_e_s + {1'b0, cur_len_s};
        end else begin
            acc_d  = acc_e_s;
            bits_d = bits_e_s;
        end
    end

    // Control FSM with all stream/status outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            line_q   <= 512'd0;
            acc_q    <= 128'd0;
            bits_q   <= 8'd0;
            k_q      <= 4'd0;
            nwords_q <= 5'd0;
            wcnt_q   <= 5'd0;
            ready_q  <= 1'b1;
            valid_q  <= 1'b0;
            sop_q    <= 1'b0;
            eop_q    <= 1'b0;
            data_q   <= 32'd0;
            done_q   <= 1'b0;
            fail_q   <= 1'b0;
            size_q   <= 5'd0;
        end else begin
            valid_q <= 1'b0;
            sop_q   <= 1'b0;
            eop_q   <= 1'b0;
            data_q  <= 32'd0;
            done_q  <= 1'b0;
            fail_q  <= 1'b0;
            size_q  <= 5'd0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.valid_i && ready_q) begin
                        line_q  <= bus.data_i;
                        ready_q <= 1'b0;
                        state_q <= ST_LEN;
                    end else begin
                        ready_q <= 1'b1;
                    end
                end
                ST_LEN: begin
                    if (len_sum_s > MAX_BITS_C) begin
                        done_q  <= 1'b1;
                        fail_q  <= 1'b1;
                        ready_q <= 1'b1;
                        state_q <= ST_IDLE;
                    end else begin
                        nwords_q <= len_pad_s[9:5];
                        acc_q    <= {PREFIX, 126'd0};
                        bits_q   <= 8'd2;
                        k_q      <= 4'd0;
                        wcnt_q   <= 5'd0;
                        state_q  <= ST_ENC;
                    end
                end
                ST_ENC: begin
                    acc_q  <= acc_d;
                    bits_q <= bits_d;
                    if (append_s) begin
                        k_q <= k_q + 4'd1;
                    end else begin
                        k_q <= k_q;
                    end
                    if (emit_s) begin
                        valid_q <= 1'b1;
                        data_q  <= acc_q[127:96];
                        sop_q   <= (wcnt_q == 5'd0);
                        wcnt_q  <= wcnt_q + 5'd1;
                        if (last_s) begin
                            eop_q   <= 1'b1;
                            done_q  <= 1'b1;
                            size_q  <= nwords_q;
                            acc_q   <= 128'd0;
                            bits_q  <= 8'd0;
                            ready_q <= 1'b1;
                            state_q <= ST_IDLE;
                        end else begin
                            state_q <= ST_ENC;
                        end
                    end else begin
                        state_q <= ST_ENC;
                    end
                end
                default: begin
                    ready_q <= 1'b1;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.ready_o = ready_q;
    assign bus.valid_o = valid_q;
    assign bus.sop_o   = sop_q;
    assign bus.eop_o   = eop_q;
    assign bus.data_o  = data_q;
    assign bus.done_o  = done_q;
    assign bus.fail_o  = fail_q;
    assign bus.size_o  = size_q;

`ifdef AIDC_LITE_COMP_ZRLE_STATS_EN
    logic [31:0] stat_lines_q;
    logic [31:0] stat_fail_q;

    // Saturating line/fail counters; clear has priority over increment.
    always_ff @(posedge clk) begin
        if (rst || stat_clr_i) begin
            stat_lines_q <= 32'd0;
            stat_fail_q  <= 32'd0;
        end else begin
            if (done_q && (stat_lines_q != {32{1'b1}})) begin
                stat_lines_q <= stat_lines_q + 32'd1;
            end else begin
                stat_lines_q <= stat_lines_q;
            end
            if (done_q && fail_q && (stat_fail_q != {32{1'b1}})) begin
                stat_fail_q <= stat_fail_q + 32'd1;
            end else begin
                stat_fail_q <= stat_fail_q;
            end
        end
    end

    assign stat_lines_o = stat_lines_q;
    assign stat_fail_o  = stat_fail_q;
`endif

endmodule

// File: tb/tb_aidc_lite_comp_zrle.sv
// Scoreboard bench for the ZRLE compressor: expected stream words and
// done status are queued when a line is driven and compared as they appear.
module tb_aidc_lite_comp_zrle;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    aidc_lite_comp_zrle_if bus();

`ifdef AIDC_LITE_COMP_ZRLE_STATS_EN
    logic        stat_clr = 1'b0;
    logic [31:0] stat_lines;
    logic [31:0] stat_fail;
`endif

    aidc_lite_comp_zrle dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus)
`ifdef AIDC_LITE_COMP_ZRLE_STATS_EN
        ,
        .stat_clr_i   (stat_clr),
        .stat_lines_o (stat_lines),
        .stat_fail_o  (stat_fail)
`endif
    );

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    int words_seen = 0;

    logic [33:0] exp_word_q [$];  // {sop, eop, data}
    logic [5:0]  exp_done_q [$];  // {fail, size}
    int          acc_cyc_q  [$];

    int tag_val [16];
    int tag_len [16];

    // Single comparison point for the whole bench.
    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Tag table indexed by Z/N pattern (bit3 = S3).
    task automatic init_tags();
        tag_val[0]  = 0;  tag_len[0]  = 6;
        tag_val[1]  = 1;  tag_len[1]  = 6;
        tag_val[2]  = 1;  tag_len[2]  = 5;
        tag_val[4]  = 2;  tag_len[4]  = 5;
        tag_val[8]  = 3;  tag_len[8]  = 5;
        tag_val[3]  = 2;  tag_len[3]  = 4;
        tag_val[5]  = 3;  tag_len[5]  = 4;
        tag_val[9]  = 4;  tag_len[9]  = 4;
        tag_val[6]  = 5;  tag_len[6]  = 4;
        tag_val[10] = 6;  tag_len[10] = 4;
        tag_val[12] = 7;  tag_len[12] = 4;
        tag_val[7]  = 8;  tag_len[7]  = 4;
        tag_val[11] = 9;  tag_len[11] = 4;
        tag_val[13] = 10; tag_len[13] = 4;
        tag_val[14] = 11; tag_len[14] = 4;
        tag_val[15] = 3;  tag_len[15] = 2;
    endtask

    // Build the expected bit stream for a line and queue words + done status.
    task automatic push_expect(input logic [511:0] line);
        bit          st [$];
        logic [63:0] w;
        logic [15:0] sym;
        int          p, nw, code_len;
        logic [31:0] d;
        st.push_back(1'b0);
        st.push_back(1'b1);
        for (int k = 0; k < 8; k++) begin
            w = line[k*64 +: 64];
            p = 0;
            for (int s = 0; s < 4; s++) if (w[s*16 +: 16] != 16'h0) p = p | (1 << s);
            for (int i = tag_len[p] - 1; i >= 0; i--) st.push_back(((tag_val[p] >> i) & 1) != 0);
            for (int s = 3; s >= 0; s--) begin
                sym = w[s*16 +: 16];
                if (sym != 16'h0) for (int b = 15; b >= 0; b--) st.push_back(sym[b]);
            end
        end
        code_len = st.size() - 2;
        if (code_len > 510) begin
            exp_done_q.push_back({1'b1, 5'd0});
        end else begin
            nw = (st.size() + 31) / 32;
            for (int i = 0; i < nw; i++) begin
                for (int j = 0; j < 32; j++) d[31-j] = (32*i + j < st.size()) ? st[32*i + j] : 1'b0;
                exp_word_q.push_back({(i == 0), (i == nw - 1), d});
            end
            exp_done_q.push_back({1'b0, 5'(nw)});
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor: pops the scoreboard on every stream word and done pulse.
    always @(negedge clk) begin
        logic [33:0] ew;
        logic [5:0]  ed;
        int          lat;
        if (!rst) begin
            if (bus.valid_o) begin
                words_seen++;
                if (exp_word_q.size() == 0) begin
                    check_val("word_not_expected", 64'(bus.valid_o), 64'd0);
                end else begin
                    ew = exp_word_q.pop_front();
                    check_val("word_data", 64'(bus.data_o), 64'(ew[31:0]));
                    check_val("word_sop", 64'(bus.sop_o), 64'(ew[33]));
                    check_val("word_eop", 64'(bus.eop_o), 64'(ew[32]));
                end
            end else begin
                check_val("idle_outputs_zero", 64'({bus.sop_o, bus.eop_o, bus.data_o}), 64'd0);
            end
            if (bus.done_o) begin
                if (exp_done_q.size() == 0) begin
                    check_val("done_not_expected", 64'(bus.done_o), 64'd0);
                end else begin
                    ed = exp_done_q.pop_front();
                    check_val("done_fail", 64'(bus.fail_o), 64'(ed[5]));
                    check_val("done_size", 64'(bus.size_o), 64'(ed[4:0]));
                    if (acc_cyc_q.size() != 0) begin
                        lat = cyc - acc_cyc_q.pop_front();
                        check_val("done_latency_le_20", 64'(lat <= 20), 64'd1);
                    end
                end
            end else begin
                check_val("nodone_fail_size_zero", 64'({bus.fail_o, bus.size_o}), 64'd0);
            end
        end
    end

    // Offer a line until accepted; optionally keep valid_i high afterwards.
    task automatic drive_line(input logic [511:0] line, input bit hold);
        int guard = 0;
        push_expect(line);
        bus.data_i  = line;
        bus.valid_i = 1'b1;
        while (!bus.ready_o && guard < 60) begin
            @(posedge clk); #1;
            guard++;
        end
        check_val("accept_ready", 64'(bus.ready_o), 64'd1);
        @(posedge clk); #1;
        acc_cyc_q.push_back(cyc);
        if (!hold) bus.valid_i = 1'b0;
    endtask

    // Wait (bounded) until every expected word and done pulse has been seen.
    task automatic wait_drain();
        int guard = 0;
        while ((exp_word_q.size() != 0 || exp_done_q.size() != 0) && guard < 80) begin
            @(negedge clk); #1;
            guard++;
        end
        check_val("drain_words_left", 64'(exp_word_q.size()), 64'd0);
        check_val("drain_done_left", 64'(exp_done_q.size()), 64'd0);
        @(posedge clk); #1;
    endtask

    function automatic logic [511:0] rand_line();
        logic [511:0] l;
        for (int i = 0; i < 32; i++) begin
            if ($urandom_range(0, 1) == 1) l[i*16 +: 16] = 16'($urandom_range(1, 65535));
            else                           l[i*16 +: 16] = 16'h0000;
        end
        return l;
    endfunction

    logic [511:0] line_a;
    logic [511:0] line_b;

    initial begin
        init_tags();
        bus.valid_i = 1'b0;
        bus.data_i  = 512'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("reset_outputs", 64'({bus.valid_o, bus.sop_o, bus.eop_o, bus.done_o,
                                         bus.fail_o, bus.size_o}), 64'd0);
        check_val("reset_data", 64'(bus.data_o), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check_val("ready_after_reset", 64'(bus.ready_o), 64'd1);

        // All-zero line: 0x40000000 then 0x00000000.
        drive_line(512'd0, 1'b0);
        wait_drain();

        // Every word ZZZN with S0=1: 6 words, first 0x41000104.
        for (int k = 0; k < 8; k++) line_a[k*64 +: 64] = 64'h0000_0000_0000_0001;
        drive_line(line_a, 1'b0);
        wait_drain();

        // All-ones: L=528, rejected.
        drive_line({512{1'b1}}, 1'b0);
        wait_drain();

        // L=498: 16 words, last holds 20 code bits.
        line_a = {512{1'b1}};
        line_a[511:448] = 64'h0000_0000_FFFF_FFFF;
        drive_line(line_a, 1'b0);
        wait_drain();

        // L=514: one over the limit.
        line_a[511:448] = 64'h0000_FFFF_FFFF_FFFF;
        drive_line(line_a, 1'b0);
        wait_drain();

        for (int r = 0; r < 6; r++) begin
            drive_line(rand_line(), 1'b0);
            wait_drain();
        end

        // Reset in the middle of a 16-word stream, after word 3.
        line_a = {512{1'b1}};
        line_a[511:448] = 64'h0000_0000_FFFF_FFFF;
        words_seen = 0;
        drive_line(line_a, 1'b0);
        for (int g = 0; g < 40 && words_seen < 4; g++) begin
            @(negedge clk); #1;
        end
        check_val("words_before_reset", 64'(words_seen), 64'd4);
        rst = 1'b1;
        @(negedge clk);
        check_val("midreset_outputs", 64'({bus.valid_o, bus.sop_o, bus.eop_o, bus.done_o,
                                            bus.fail_o, bus.size_o}), 64'd0);
        check_val("midreset_data", 64'(bus.data_o), 64'd0);
        exp_word_q.delete();
        exp_done_q.delete();
        acc_cyc_q.delete();
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check_val("ready_after_midreset", 64'(bus.ready_o), 64'd1);
        drive_line(512'd0, 1'b0);
        wait_drain();

`ifdef AIDC_LITE_COMP_ZRLE_STATS_EN
        stat_clr = 1'b1;
        @(posedge clk); #1;
        stat_clr = 1'b0;
`endif

        // valid_i held across two lines: second accepted only after first completes.
        line_a = rand_line();
        line_b = {512{1'b0}};
        for (int k = 0; k < 8; k++) line_b[k*64 +: 64] = 64'hABCD_0000_1234_0000;
        drive_line(line_a, 1'b1);
        check_val("busy_after_accept", 64'(bus.ready_o), 64'd0);
        drive_line(line_b, 1'b0);
        wait_drain();

`ifdef AIDC_LITE_COMP_ZRLE_STATS_EN
        check_val("stat_lines", 64'(stat_lines), 64'd2);
        check_val("stat_fail", 64'(stat_fail), 64'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
